// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: issue, result, operand and status signals of the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2
);
  logic                  adv;
  logic                  flush;
  logic                  iss_valid;
  logic                  iss_wen;
  logic                  iss_load;
  logic [AW-1:0]         iss_dst;
  logic [DEPTH-1:0]      res_we;
  logic [DEPTH*DW-1:0]   res_data;
  logic [NSRC*AW-1:0]    src_reg;
  logic [NSRC*DW-1:0]    src_rfdata;
  logic [NSRC*DW-1:0]    fwd_data;
  logic [NSRC-1:0]       fwd_hit;
  logic                  stall;
  logic [15:0]           stall_cycles;
  logic [15:0]           stall_events;
  modport master (
    output adv, flush, iss_valid, iss_wen, iss_load, iss_dst, res_we, res_data, src_reg, src_rfdata,
    input  fwd_data, fwd_hit, stall, stall_cycles, stall_events
  );
  modport slave (
    input  adv, flush, iss_valid, iss_wen, iss_load, iss_dst, res_we, res_data, src_reg, src_rfdata,
    output fwd_data, fwd_hit, stall, stall_cycles, stall_events
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracking with youngest-first operand bypass and stall detection
module hazard_scoreboard #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2
) (
  input logic                 i_CLK,
  input logic                 i_nRST,
  hazard_scoreboard_if.slave  sb
);
  typedef struct packed {
    logic          valid;
    logic          wen;
    logic          load;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic          ok;
  } slot_t;
  typedef enum logic {RUN, STALL} state_t;
  slot_t            r_slot [DEPTH];
  slot_t            w_cap  [DEPTH];
  slot_t            w_nxt  [DEPTH];
  slot_t            w_iss;
  state_t           r_state;
  logic [15:0]      r_cyc;
  logic [15:0]      r_ev;
  logic [NSRC-1:0]  w_found;
  logic [NSRC-1:0]  w_pend;
  logic [NSRC-1:0]  w_hit;
  logic [NSRC*DW-1:0] w_fwd;
  logic             w_stall;
  // slot contents after this cycle's result strobes, before any shift
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_cap[k] = r_slot[k];
      if (sb.res_we[k] && r_slot[k].valid && r_slot[k].wen) begin
        w_cap[k].data = sb.res_data[k*DW +: DW];
        w_cap[k].ok   = 1'b1;
      end
    end
  end
  always_comb begin
    w_iss = {sb.iss_valid & ~w_stall, sb.iss_wen, sb.iss_load, sb.iss_dst, {DW{1'b0}}, 1'b0};
    w_nxt[0] = sb.adv ? w_iss : w_cap[0];
    if (sb.flush) w_nxt[0].valid = 1'b0;
    for (int k = 1; k < DEPTH; k++) w_nxt[k] = sb.adv ? w_cap[k-1] : w_cap[k];
  end
  // the first match decides, so an older slot with data never masks a younger pending one
  always_comb begin
    w_found = '0;
    w_pend  = '0;
    w_hit   = '0;
    w_fwd   = sb.src_rfdata;
    for (int i = 0; i < NSRC; i++)
      for (int k = 0; k < DEPTH; k++)
        if (!w_found[i] && r_slot[k].valid && r_slot[k].wen &&
            r_slot[k].dst == sb.src_reg[i*AW +: AW] && sb.src_reg[i*AW +: AW] != '0) begin
          w_found[i] = 1'b1;
          if (r_slot[k].ok) begin
            w_fwd[i*DW +: DW] = r_slot[k].data;
            w_hit[i]          = 1'b1;
          end else if (sb.res_we[k]) begin
            w_fwd[i*DW +: DW] = sb.res_data[k*DW +: DW];
            w_hit[i]          = 1'b1;
          end else w_pend[i] = 1'b1;
        end
  end
  assign w_stall         = |w_pend;
  assign sb.stall        = w_stall;
  assign sb.fwd_hit      = w_hit;
  assign sb.fwd_data     = w_fwd;
  assign sb.stall_cycles = r_cyc;
  assign sb.stall_events = r_ev;
  always_ff @(posedge i_CLK) begin
    if (i_nRST) begin
      for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
      r_state <= RUN;
      r_cyc   <= '0;
      r_ev    <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) r_slot[k] <= w_nxt[k];
      r_state <= w_stall ? STALL : RUN;
      if (w_stall && r_cyc != 16'hFFFF) r_cyc <= r_cyc + 16'd1;
      if (w_stall && r_state == RUN && r_ev != 16'hFFFF) r_ev <= r_ev + 16'd1;
    end
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameters DW=32 (data width), AW=5 (register index width), DEPTH=3 (in-flight slots; slot 0=EX, slot DEPTH-1=WB), NSRC=2 (source operand ports).
REQ-002 SHALL have CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have nRST  in  1  reset; synchronous, active-high (1 = reset).
REQ-004 SHALL have adv  in  1  pipeline advance; slots shift when 1.
REQ-005 SHALL have flush  in  1  squash of the instruction entering slot 0.
REQ-006 SHALL have iss_valid, iss_wen, iss_load  in  1 each  issuing instruction is valid, writes a register, or is a load.
REQ-007 SHALL have iss_dst  in  AW  issuing instruction destination register.
REQ-008 SHALL have res_we  in  DEPTH  per-slot result-valid strobe.
REQ-009 SHALL have res_data  in  DEPTH*DW  per-slot result; slot s at [s*DW +: DW].
REQ-010 SHALL have src_reg  in  NSRC*AW and src_rfdata  in  NSRC*DW  source register indices and register-file read data.
REQ-011 SHALL have fwd_data  out  NSRC*DW and fwd_hit  out  NSRC  resolved operand and bypass indicator per source.
REQ-012 SHALL have stall  out  1  operand not yet available.
REQ-013 SHALL have stall_cycles  out  16 and stall_events  out  16  saturating performance counters.

Function
REQ-014 Each slot SHALL hold {valid, wen, load, dst, data, data_ok}.
REQ-015 On adv=1, slot s SHALL take slot s-1 for s>=1, slot DEPTH-1 retires, and slot 0 SHALL load {iss_valid & ~stall, iss_wen, iss_load, iss_dst, data_ok=0}; while stall=1 a bubble (valid=0) enters.
REQ-016 On adv=0, slots SHALL hold, except for result capture.
REQ-017 res_we[s]=1 on a valid, wen slot SHALL set data=res_data[s] and data_ok=1; with adv=1 the captured value SHALL travel with the entry into slot s+1, or be dropped if s=DEPTH-1.
REQ-018 flush=1 SHALL force next slot 0 valid=0 and take priority over issue, regardless of adv.
REQ-019 For each source i, slots SHALL be searched youngest first (slot 0 up) for valid & wen & dst==src_reg[i] & src_reg[i]!=0.
REQ-020 First match with data_ok=1 SHALL give fwd_data=slot data and fwd_hit=1.
REQ-021 First match with data_ok=0 and res_we[s]=1 in the same cycle SHALL give fwd_data=res_data[s] and fwd_hit=1, with no stall.
REQ-022 First match with no data available SHALL give pending=1, fwd_data=src_rfdata[i] and fwd_hit=0.
REQ-023 No match, or src_reg=0, SHALL give fwd_data=src_rfdata[i] and fwd_hit=0.
REQ-024 stall SHALL be the combinational OR of pending over all sources; zero latency.
REQ-025 An older matching slot SHALL never override a younger one, even if only the older one has data.
REQ-026 State machine RUN/STALL SHALL follow RUN->STALL when stall=1, STALL->RUN when stall=0, and otherwise hold.
REQ-027 stall_cycles SHALL increment each cycle stall=1 and stall_events on each RUN->STALL transition; both SHALL saturate at 0xFFFF.

Reset
REQ-028 nRST=1 at a clock edge SHALL clear every slot (valid=0, data_ok=0, data=0), set state RUN and zero both counters, overriding adv, flush and res_we in that cycle.
REQ-029 After reset with no slots valid, outputs SHALL be fwd_data=src_rfdata, fwd_hit=0 and stall=0.
REQ-030 Reset mid-stall SHALL deassert stall from the next cycle, with no residual forwarding.

Verification
REQ-031 ALU bypass: issue wen dst=3, adv; res_we[0]=1 data 0x10; src_reg[0]=3 -> fwd_hit[0]=1, fwd_data 0x10, stall=0 in the same cycle.
REQ-032 Load-use: issue load dst=5, adv; next src_reg[0]=5 with no res_we -> stall=1 and a bubble enters on adv; then res_we[1]=1 data 0xDEAD -> fwd_data 0xDEAD, stall=0; stall_cycles=1, stall_events=1.
REQ-033 Youngest wins: slot 0 dst=4 data 1, slot 1 dst=4 data 2, src_reg=4 -> fwd_data=1; slot 0 dst=4 without data_ok -> stall=1 even though slot 1 has data.
REQ-034 Register 0: in-flight dst=0 with data 0x55, src_reg=0, rfdata 0 -> fwd_hit=0, fwd_data 0, stall=0.
REQ-035 Flush: iss_valid=1 dst=7 with flush=1 and adv=1; then src_reg=7 -> no hit, rfdata passed through, stall=0.
REQ-036 Reset mid-stall: nRST=1 while stall=1 and counters nonzero -> next cycle stall=0, stall_cycles=0, stall_events=0, all fwd_hit=0.
